// File: rtl/ccd_line_timing_pkg.sv
// Shared constants and state encoding for the linear-CCD line timing generator.
// The column split must stay in step with the downstream ccd2axis stage.
package ccd_line_timing_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSh,
    StGap,
    StRead,
    StWait
  } ccd_state_e;

  localparam int unsigned PRE_COLS       = 32;
  localparam int unsigned EFFECT_COLS    = 2048;
  localparam int unsigned POST_COLS      = 8;
  localparam int unsigned TOTAL_COLS_DEF = PRE_COLS + EFFECT_COLS + POST_COLS;

  // Shortest line that still fits the shift gate, the gap, a full window and the blanking.
  function automatic int unsigned calc_min_period(input int unsigned sh_width,
                                                  input int unsigned sh_to_valid,
                                                  input int unsigned total_cols,
                                                  input int unsigned min_blank);
    return sh_width + sh_to_valid + total_cols + min_blank;
  endfunction

endpackage

// File: rtl/ccd_line_timing_if.sv
// Readout stream from the line timing generator towards ccd2axis (no backpressure).
interface ccd_line_timing_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata);
  modport slave  (input tvalid, input tdata);
endinterface

// File: rtl/ccd_line_timing.sv
// Linear-CCD line timing generator: shift-gate pulse, then one contiguous readout window
// per line, with a runtime line period clamped to the hardware minimum.
module ccd_line_timing
  import ccd_line_timing_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TOTAL_COLS  = TOTAL_COLS_DEF,
  parameter int unsigned SH_WIDTH    = 16,
  parameter int unsigned SH_TO_VALID = 8,
  parameter int unsigned MIN_BLANK   = 2,
  parameter int unsigned PERIOD_W    = 20
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PERIOD_W-1:0]   line_period,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  ccd_sh,
  ccd_line_timing_if.master     stream,
  output logic                  line_start,
  output logic [15:0]           line_cnt,
  output logic                  busy,
  output logic                  period_err
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD =
      PERIOD_W'(calc_min_period(SH_WIDTH, SH_TO_VALID, TOTAL_COLS, MIN_BLANK));
  localparam logic [PERIOD_W-1:0] SH_LAST   = PERIOD_W'(SH_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] GAP_LAST  = PERIOD_W'(SH_WIDTH + SH_TO_VALID - 1);
  localparam logic [PERIOD_W-1:0] READ_LAST =
      PERIOD_W'(SH_WIDTH + SH_TO_VALID + TOTAL_COLS - 1);

  ccd_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] p_q, p_d;
  logic [PERIOD_W-1:0] eff_q, eff_d;
  logic                enable_q;
  logic                sample;
  logic                clamp;
  logic                en_rise;
  logic [15:0]         line_cnt_d;
  logic                period_err_d;

  always_comb begin
    state_d      = state_q;
    p_d          = p_q + 1'b1;
    eff_d        = eff_q;
    sample       = 1'b0;
    clamp        = (line_period < MIN_PERIOD);
    en_rise      = enable & ~enable_q;

    case (state_q)
      StIdle: begin
        p_d = '0;
        if (enable) begin
          state_d = StSh;
          sample  = 1'b1;
        end
      end
      StSh:   if (p_q == SH_LAST)   state_d = StGap;
      StGap:  if (p_q == GAP_LAST)  state_d = StRead;
      StRead: if (p_q == READ_LAST) state_d = StWait;
      StWait: begin
        // eff >= MIN_PERIOD guarantees at least MIN_BLANK cycles here.
        if (p_q == eff_q - 1'b1) begin
          p_d = '0;
          if (enable) begin
            state_d = StSh;
            sample  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        p_d     = '0;
      end
    endcase

    if (sample) begin
      eff_d = clamp ? MIN_PERIOD : line_period;
    end

    // Enable rise clears the line statistics before this cycle's sample is applied.
    line_cnt_d   = (en_rise ? 16'd0 : line_cnt) + 16'(sample);
    period_err_d = (en_rise ? 1'b0 : period_err) | (sample & clamp);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      p_q           <= '0;
      eff_q         <= MIN_PERIOD;
      enable_q      <= 1'b0;
      line_cnt      <= '0;
      period_err    <= 1'b0;
      ccd_sh        <= 1'b0;
      line_start    <= 1'b0;
      busy          <= 1'b0;
      stream.tvalid <= 1'b0;
      stream.tdata  <= '0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      eff_q         <= eff_d;
      enable_q      <= enable;
      line_cnt      <= line_cnt_d;
      period_err    <= period_err_d;
      ccd_sh        <= (state_d == StSh);
      line_start    <= sample;
      busy          <= (state_d != StIdle);
      stream.tvalid <= (state_d == StRead);
      stream.tdata  <= adc_data;
    end
  end

endmodule

// File: tb/tb_ccd_line_timing.sv
// Directed bench for ccd_line_timing with a short line (MIN_PERIOD = 4 + 2 + 10 + 2 = 18).
module tb_ccd_line_timing;

  localparam int unsigned DW  = 8;
  localparam int unsigned TC  = 10;
  localparam int unsigned SHW = 4;
  localparam int unsigned STV = 2;
  localparam int unsigned MB  = 2;
  localparam int unsigned PW  = 20;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] line_period;
  logic [DW-1:0] adc_data;
  logic          ccd_sh;
  logic          line_start;
  logic [15:0]   line_cnt;
  logic          busy;
  logic          period_err;

  ccd_line_timing_if #(.DATA_WIDTH(DW)) st ();

  ccd_line_timing #(
    .DATA_WIDTH (DW),
    .TOTAL_COLS (TC),
    .SH_WIDTH   (SHW),
    .SH_TO_VALID(STV),
    .MIN_BLANK  (MB),
    .PERIOD_W   (PW)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .enable     (enable),
    .line_period(line_period),
    .adc_data   (adc_data),
    .ccd_sh     (ccd_sh),
    .stream     (st),
    .line_start (line_start),
    .line_cnt   (line_cnt),
    .busy       (busy),
    .period_err (period_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int sh_rise_q[$], sh_fall_q[$], tv_rise_q[$], tv_fall_q[$], ls_q[$], lc_q[$];
  logic sh_prev = 1'b0;
  logic tv_prev = 1'b0;

  always @(negedge pixel_clk) begin
    if (ccd_sh && !sh_prev)       sh_rise_q.push_back(cyc);
    if (!ccd_sh && sh_prev)       sh_fall_q.push_back(cyc);
    if (st.tvalid && !tv_prev)    tv_rise_q.push_back(cyc);
    if (!st.tvalid && tv_prev)    tv_fall_q.push_back(cyc);
    if (line_start) begin
      ls_q.push_back(cyc);
      lc_q.push_back(int'(line_cnt));
    end
    sh_prev <= ccd_sh;
    tv_prev <= st.tvalid;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle; every readout cycle must carry the sample driven one cycle earlier.
  task automatic step();
    @(negedge pixel_clk);
    if (st.tvalid) check("tdata_ramp", int'(st.tdata), int'(adc_data));
    adc_data = adc_data + 8'd1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic clear_q();
    sh_rise_q.delete(); sh_fall_q.delete(); tv_rise_q.delete();
    tv_fall_q.delete(); ls_q.delete(); lc_q.delete();
  endtask

  // Three lines starting at t0; line 2 starts per0 later, line 3 per1 after that.
  task automatic check_lines(input int t0, input int per0, input int per1);
    int exp_rise;
    int n_ok;
    check("n_sh_rise", sh_rise_q.size(), 3);
    check("n_sh_fall", sh_fall_q.size(), 3);
    check("n_tv_rise", tv_rise_q.size(), 3);
    check("n_tv_fall", tv_fall_q.size(), 3);
    check("n_line_start", ls_q.size(), 3);
    n_ok = n_err;
    if (sh_rise_q.size() == 3 && sh_fall_q.size() == 3 && tv_rise_q.size() == 3 &&
        tv_fall_q.size() == 3 && ls_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_rise = t0 + ((i > 0) ? per0 : 0) + ((i > 1) ? per1 : 0);
        check("sh_rise_time", sh_rise_q[i], exp_rise);
        check("sh_width", sh_fall_q[i] - sh_rise_q[i], SHW);
        check("tv_lead", tv_rise_q[i] - sh_rise_q[i], SHW + STV);
        check("tv_width", tv_fall_q[i] - tv_rise_q[i], TC);
        check("line_start_time", ls_q[i], exp_rise);
        check("line_cnt", lc_q[i], i + 1);
      end
      check("tv_gap0", tv_rise_q[1] - tv_fall_q[0], per0 - TC);
      check("tv_gap1", tv_rise_q[2] - tv_fall_q[1], per1 - TC);
    end
    n_ok = n_ok;
  endtask

  int t0;

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    line_period = '0;
    adc_data    = 8'h55;
    repeat (3) step();
    check("rst_ccd_sh", int'(ccd_sh), 0);
    check("rst_tvalid", int'(st.tvalid), 0);
    check("rst_line_start", int'(line_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period_err", int'(period_err), 0);
    check("rst_line_cnt", int'(line_cnt), 0);
    check("rst_tdata", int'(st.tdata), 0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_busy", int'(busy), 0);
    check("idle_ccd_sh", int'(ccd_sh), 0);

    // Period 30, enable dropped mid-READ of line 3: window completes, WAIT ends at p=29.
    clear_q();
    enable      = 1'b1;
    line_period = 30;
    t0          = cyc + 1;
    run_to(t0);
    check("t1_period_err", int'(period_err), 0);
    run_to(t0 + 70);
    check("t4_in_read", int'(st.tvalid), 1);
    enable = 1'b0;
    run_to(t0 + 89);
    check("t4_busy_last_wait", int'(busy), 1);
    step();
    check("t4_busy_idle", int'(busy), 0);
    run_to(t0 + 130);
    check_lines(t0, 30, 30);

    // Period 5 clamps to 18.
    clear_q();
    enable      = 1'b1;
    line_period = 5;
    t0          = cyc + 1;
    run_to(t0);
    check("t2_period_err_set", int'(period_err), 1);
    run_to(t0 + 44);
    enable = 1'b0;
    run_to(t0 + 53);
    check("t2_busy_last_wait", int'(busy), 1);
    step();
    check("t2_busy_idle", int'(busy), 0);
    run_to(t0 + 80);
    check_lines(t0, 18, 18);
    check("t2_period_err_sticky", int'(period_err), 1);

    // Period changed 30 -> 40 during READ: only the next line picks it up.
    clear_q();
    enable      = 1'b1;
    line_period = 30;
    t0          = cyc + 1;
    run_to(t0);
    check("t5_period_err_cleared", int'(period_err), 0);
    run_to(t0 + 8);
    line_period = 40;
    run_to(t0 + 80);
    enable = 1'b0;
    run_to(t0 + 110);
    check("t5_busy_idle", int'(busy), 0);
    run_to(t0 + 130);
    check_lines(t0, 30, 40);

    // Reset in the 5th READ cycle.
    clear_q();
    enable      = 1'b1;
    line_period = 5;
    t0          = cyc + 1;
    run_to(t0 + 10);
    check("t6_pre_tvalid", int'(st.tvalid), 1);
    check("t6_pre_period_err", int'(period_err), 1);
    rst         = 1'b1;
    line_period = 30;
    step();
    check("t6_rst_tvalid", int'(st.tvalid), 0);
    check("t6_rst_ccd_sh", int'(ccd_sh), 0);
    check("t6_rst_line_cnt", int'(line_cnt), 0);
    check("t6_rst_period_err", int'(period_err), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_tdata", int'(st.tdata), 0);
    rst = 1'b0;
    step();
    check("t6_line_start", int'(line_start), 1);
    check("t6_ccd_sh", int'(ccd_sh), 1);
    check("t6_line_cnt", int'(line_cnt), 1);
    check("t6_period_err", int'(period_err), 0);
    enable = 1'b0;
    run_to(cyc + 40);
    check("t6_busy_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
